// File: rtl/iob_mem_arbiter_pkg.sv
// rtl/iob_mem_arbiter_pkg.sv - FSM state type and bus-width helpers for the memory arbiter
package iob_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_BUSY = 2'd2
   } arb_state_t;

   // Request is packed {valid, address, wdata, wstrb}; response is {rdata, ready}.
   function automatic int req_width(input int addr_w, input int data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction

   function automatic int resp_width(input int data_w);
      return data_w + 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/iob_rr_prio.sv
// rtl/iob_rr_prio.sv - combinational round-robin priority encoder, one-hot winner
module iob_rr_prio
   import iob_mem_arbiter_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     winner
);

   // Scan starts one past the previous owner so it gets the lowest priority.
   always_comb begin
      winner = '0;
      for (int k = 1; k <= N; k++) begin
         if (req[(int'(last) + k) % N] && (winner == '0)) begin
            winner[(int'(last) + k) % N] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/iob_mem_arbiter.sv
// rtl/iob_mem_arbiter.sv - round-robin arbiter sharing one native memory slave, with timeout
module iob_mem_arbiter
   import iob_mem_arbiter_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = 8,
   localparam int REQ_W    = req_width(ADDR_W, DATA_W),
   localparam int RESP_W   = resp_width(DATA_W)
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [N_MASTERS*REQ_W-1:0]    m_req,
   output logic [N_MASTERS*RESP_W-1:0]   m_resp,
   output logic [REQ_W-1:0]              s_req,
   input  logic [RESP_W-1:0]             s_resp,
   output logic [N_MASTERS-1:0]          grant,
   output logic                          timeout_err
);

   localparam int IDX_W = idx_width(N_MASTERS);
   // Timeout fires on the (2^TIMEOUT_W - 1)th BUSY cycle; the counter holds prior BUSY cycles.
   localparam logic [TIMEOUT_W-1:0] TOUT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
   localparam logic [IDX_W-1:0]     LAST_RST  = IDX_W'(N_MASTERS - 1);

   arb_state_t           state_q, state_d;
   logic [N_MASTERS-1:0] req_valid;
   logic [N_MASTERS-1:0] prio_win;
   logic [N_MASTERS-1:0] grant_q;
   logic [IDX_W-1:0]     prio_idx;
   logic [IDX_W-1:0]     win_q;
   logic [IDX_W-1:0]     last_q;
   logic [TIMEOUT_W-1:0] tcnt_q;
   logic [REQ_W-2:0]     win_fields;

   for (genvar i = 0; i < N_MASTERS; i++) begin : g_valid
      assign req_valid[i] = m_req[i*REQ_W + REQ_W - 1];
   end

   iob_rr_prio #(
      .N     (N_MASTERS),
      .IDX_W (IDX_W)
   ) u_prio (
      .req    (req_valid),
      .last   (last_q),
      .winner (prio_win)
   );

   always_comb begin
      prio_idx = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (prio_win[i]) prio_idx = IDX_W'(i);
      end
   end

   assign win_fields = m_req[int'(win_q)*REQ_W +: REQ_W-1];
   assign grant      = grant_q;

   always_comb begin
      state_d     = state_q;
      s_req       = '0;
      m_resp      = '0;
      timeout_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) state_d = ST_ARB;
         end
         ST_ARB: begin
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            // Valid is forced so a master dropping valid early cannot strand the slave.
            s_req = {1'b1, win_fields};
            m_resp[int'(win_q)*RESP_W +: RESP_W] = s_resp;
            if (s_resp[0]) begin
               state_d = ST_IDLE;
            end else if (tcnt_q == TOUT_LAST) begin
               s_req[REQ_W-1] = 1'b0;
               m_resp[int'(win_q)*RESP_W +: RESP_W] = {{DATA_W{1'b0}}, 1'b1};
               timeout_err = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         win_q   <= '0;
         last_q  <= LAST_RST;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (state_d == ST_ARB) begin
                  grant_q <= prio_win;
                  win_q   <= prio_idx;
                  tcnt_q  <= '0;
               end
            end
            ST_BUSY: begin
               if (state_d == ST_IDLE) begin
                  grant_q <= '0;
                  last_q  <= win_q;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// tb/tb_iob_mem_arbiter.sv - randomized self-checking bench for iob_mem_arbiter
module tb_iob_mem_arbiter;

   localparam int N      = 2;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int TW     = 4;
   localparam int SW     = DW / 8;
   localparam int REQ_W  = 1 + AW + DW + SW;
   localparam int RESP_W = DW + 1;
   localparam int TLIM   = (1 << TW) - 1;

   logic                  clk = 1'b0;
   logic                  resetn = 1'b0;
   logic [N*REQ_W-1:0]    m_req = '0;
   logic [N*RESP_W-1:0]   m_resp;
   logic [REQ_W-1:0]      s_req;
   logic [RESP_W-1:0]     s_resp = '0;
   logic [N-1:0]          grant;
   logic                  timeout_err;

   always #5 clk = ~clk;

   iob_mem_arbiter #(
      .N_MASTERS (N),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .TIMEOUT_W (TW)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .m_req       (m_req),
      .m_resp      (m_resp),
      .s_req       (s_req),
      .s_resp      (s_resp),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   int tests = 0;
   int fails = 0;

   // master side: one outstanding request per master, held until served
   bit              pend     [N];
   logic [AW-1:0]   addr     [N];
   logic [DW-1:0]   wdata    [N];
   logic [SW-1:0]   wstrb    [N];
   int              req_prob [N];
   int              done_cnt [N];

   // reference model: owner=-1 idle; age 0 = arbitration cycle, age k>=1 = k-th slave cycle
   int owner = -1;
   int age   = 0;
   int last  = N - 1;
   int delay = 0;

   int          fix_delay  = -1;
   int          dly_max    = 17;
   int          noise_prob = 0;
   bit          fix_rd_en  = 1'b0;
   logic [DW-1:0] fix_rd   = '0;

   int          terr_seen = 0;
   logic [N-1:0] arb_grants[$];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic new_req(input int i);
      pend[i]  = 1'b1;
      addr[i]  = AW'($urandom);
      wdata[i] = DW'($urandom);
      wstrb[i] = SW'($urandom);
   endtask

   task automatic step(input logic rst_n);
      logic [REQ_W-1:0]    er;
      logic [N*RESP_W-1:0] emr;
      logic [N-1:0]        eg;
      logic                et;
      logic                rdy;
      bit                  found;
      @(posedge clk);
      #1;
      resetn = rst_n;
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && ($urandom_range(99) < req_prob[i])) new_req(i);
         m_req[i*REQ_W +: REQ_W] = {pend[i], addr[i], wdata[i], wstrb[i]};
      end
      if (owner >= 0 && age >= 1) rdy = (age == delay);
      else                        rdy = ($urandom_range(99) < noise_prob);
      if (!rst_n) rdy = 1'b0;
      s_resp = {fix_rd_en ? fix_rd : DW'($urandom), rdy};

      @(negedge clk);
      eg  = '0;
      er  = '0;
      emr = '0;
      et  = 1'b0;
      if (owner >= 0) begin
         eg[owner] = 1'b1;
         if (age >= 1) begin
            et = !s_resp[0] && (age == TLIM);
            er = {!et, addr[owner], wdata[owner], wstrb[owner]};
            emr[owner*RESP_W +: RESP_W] = et ? RESP_W'(1) : s_resp;
         end
      end
      check("grant", 128'(grant), 128'(eg));
      check("s_req", 128'(s_req), 128'(er));
      check("m_resp", 128'(m_resp), 128'(emr));
      check("timeout_err", 128'(timeout_err), 128'(et));
      if (timeout_err) terr_seen++;
      if (owner >= 0 && age == 0) arb_grants.push_back(grant);

      if (!rst_n) begin
         owner = -1;
         age   = 0;
         last  = N - 1;
         for (int i = 0; i < N; i++) pend[i] = 1'b0;
      end else if (owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            if (!found && pend[(last + k) % N]) begin
               owner = (last + k) % N;
               found = 1'b1;
            end
         end
         if (found) begin
            age   = 0;
            delay = (fix_delay >= 0) ? fix_delay : int'($urandom_range(dly_max, 1));
         end
      end else if (age == 0) begin
         age = 1;
      end else if (s_resp[0] || age == TLIM) begin
         pend[owner] = 1'b0;
         done_cnt[owner]++;
         last  = owner;
         owner = -1;
      end else begin
         age++;
      end
   endtask

   int d0;
   int d1;

   initial begin
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
         req_prob[i] = 0; done_cnt[i] = 0;
      end

      // reset
      repeat (3) step(1'b0);
      check("rst_grant", 128'(grant), 128'(0));
      check("rst_s_req", 128'(s_req), 128'(0));
      step(1'b1);

      // single read from master 1, slave ready 3 cycles after s_req valid
      pend[1] = 1'b1; addr[1] = 32'h80; wdata[1] = '0; wstrb[1] = '0;
      fix_delay = 4; fix_rd_en = 1'b1; fix_rd = 32'hDEADBEEF;
      repeat (10) step(1'b1);
      check("single_done_m1", 128'(done_cnt[1]), 128'(1));
      check("single_done_m0", 128'(done_cnt[0]), 128'(0));

      // contention, both masters always requesting
      arb_grants.delete();
      fix_delay = 1; fix_rd_en = 1'b0;
      req_prob[0] = 100; req_prob[1] = 100;
      repeat (14) step(1'b1);
      req_prob[0] = 0; req_prob[1] = 0;
      repeat (8) step(1'b1);
      check("cont_count", 128'(arb_grants.size() >= 4), 128'(1));
      for (int k = 0; k < 4; k++) begin
         if (k < arb_grants.size()) check("cont_seq", 128'(arb_grants[k]), 128'((k % 2 == 0) ? 1 : 2));
      end

      // write passthrough from master 0
      d0 = done_cnt[0];
      pend[0] = 1'b1; addr[0] = 32'h100; wdata[0] = 32'h12345678; wstrb[0] = 4'b0011;
      fix_delay = 5;
      repeat (10) step(1'b1);
      check("write_done", 128'(done_cnt[0]), 128'(d0 + 1));

      // timeout: slave never answers, then a normal transaction
      terr_seen = 0;
      d1 = done_cnt[1];
      new_req(1);
      fix_delay = 99;
      repeat (20) step(1'b1);
      check("tout_pulses", 128'(terr_seen), 128'(1));
      check("tout_done", 128'(done_cnt[1]), 128'(d1 + 1));
      d0 = done_cnt[0];
      new_req(0);
      fix_delay = 2;
      repeat (8) step(1'b1);
      check("after_tout_done", 128'(done_cnt[0]), 128'(d0 + 1));
      check("after_tout_pulses", 128'(terr_seen), 128'(1));

      // ready on the same cycle the timeout is reached
      terr_seen = 0;
      new_req(0);
      fix_delay = 15; fix_rd_en = 1'b1; fix_rd = 32'hA5A5A5A5;
      repeat (20) step(1'b1);
      check("tie_no_tout", 128'(terr_seen), 128'(0));
      fix_rd_en = 1'b0;

      // reset in the middle of a transaction
      new_req(0); new_req(1);
      fix_delay = 99;
      repeat (5) step(1'b1);
      step(1'b0);
      step(1'b1);
      check("midrst_grant", 128'(grant), 128'(0));
      arb_grants.delete();
      new_req(0); new_req(1);
      fix_delay = 2;
      repeat (6) step(1'b1);
      check("midrst_first_cnt", 128'(arb_grants.size() >= 1), 128'(1));
      if (arb_grants.size() >= 1) check("midrst_first_win", 128'(arb_grants[0]), 128'(1));
      repeat (10) step(1'b1);

      // randomized traffic with stray ready and occasional reset
      fix_delay = -1; dly_max = 17; noise_prob = 20;
      for (int r = 0; r < 1500; r++) begin
         if (r % 100 == 0) begin
            req_prob[0] = int'($urandom_range(90, 20));
            req_prob[1] = int'($urandom_range(90, 20));
         end
         step(($urandom_range(199) != 0) ? 1'b1 : 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
